// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: decoder stimulus/result bundle.
// master drives en, window_len, spike_in and observes the results;
// slave (the decoder) drives rate_out, latency_out, first_seen, overflow, valid.
interface spike_rate_decoder_if #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIN_W-1:0] window_len;
    logic             spike_in;
    logic [CNT_W-1:0] rate_out;
    logic [WIN_W-1:0] latency_out;
    logic             first_seen;
    logic             overflow;
    logic             valid;
    modport master (
        output en, window_len, spike_in,
        input  rate_out, latency_out, first_seen, overflow, valid
    );
    modport slave (
        input  en, window_len, spike_in,
        output rate_out, latency_out, first_seen, overflow, valid
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike count and first-spike latency decoder.
// Ports: clk, rst (sync, active-high); bus (slave) carries en, window_len,
// spike_in in and rate_out, latency_out, first_seen, overflow, valid out.
module spike_rate_decoder #(
    parameter int WIN_W     = 8,
    parameter int CNT_W     = 8,
    parameter bit EDGE_MODE = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    spike_rate_decoder_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d, idx_q, idx_d, lat_q, lat_d, lat_o_q, lat_o_d;
    logic [WIN_W-1:0] cur_len, lat_n;
    logic [CNT_W-1:0] cnt_q, cnt_d, rate_q, rate_d, cnt_n;
    logic             seen_q, seen_d, ovf_q, ovf_d, prev_q, prev_d;
    logic             first_q, first_d, ovf_o_q, ovf_o_d, valid_q, valid_d;
    logic             hit, sat, last, clr, seen_n, ovf_n;

    assign bus.rate_out    = rate_q;
    assign bus.latency_out = lat_o_q;
    assign bus.first_seen  = first_q;
    assign bus.overflow    = ovf_o_q;
    assign bus.valid       = valid_q;

    always_comb begin
        // Cycle 0 of every window (from IDLE or back-to-back) re-samples window_len.
        cur_len = (state_q == IDLE || idx_q == '0)
                ? ((bus.window_len == '0) ? WIN_W'(1) : bus.window_len) : len_q;
        // prev_q is already 0 on the first window cycle because IDLE clears it.
        hit     = bus.spike_in && (!EDGE_MODE || !prev_q);
        sat     = &cnt_q;
        cnt_n   = (hit && !sat) ? cnt_q + CNT_W'(1) : cnt_q;
        ovf_n   = ovf_q | (hit & sat);
        lat_n   = (hit && !seen_q) ? idx_q : lat_q;
        seen_n  = seen_q | hit;
        last    = idx_q == cur_len - WIN_W'(1);
        clr     = !bus.en || last;
        state_d = bus.en ? RUN : IDLE;
        len_d   = bus.en ? cur_len : len_q;
        idx_d   = clr ? '0 : idx_q + WIN_W'(1);
        cnt_d   = clr ? '0 : cnt_n;
        lat_d   = clr ? '0 : lat_n;
        seen_d  = clr ? 1'b0 : seen_n;
        ovf_d   = clr ? 1'b0 : ovf_n;
        prev_d  = bus.en & bus.spike_in;
        valid_d = bus.en & last;
        rate_d  = valid_d ? cnt_n : rate_q;
        lat_o_d = valid_d ? (seen_n ? lat_n : '1) : lat_o_q;
        first_d = valid_d ? seen_n : first_q;
        ovf_o_d = valid_d ? ovf_n : ovf_o_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            prev_q  <= 1'b0;
            rate_q  <= '0;
            lat_o_q <= '1;
            first_q <= 1'b0;
            ovf_o_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            prev_q  <= prev_d;
            rate_q  <= rate_d;
            lat_o_q <= lat_o_d;
            first_q <= first_d;
            ovf_o_q <= ovf_o_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed checks of spike_rate_decoder in three configurations.
module tb_spike_rate_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] wlen = 8'd0;
    logic       spk = 1'b0;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.WIN_W(8), .CNT_W(8)) b0 ();
    spike_rate_decoder_if #(.WIN_W(8), .CNT_W(3)) b1 ();
    spike_rate_decoder_if #(.WIN_W(8), .CNT_W(3)) b2 ();

    assign b0.en = en;
    assign b0.window_len = wlen;
    assign b0.spike_in = spk;
    assign b1.en = en;
    assign b1.window_len = wlen;
    assign b1.spike_in = spk;
    assign b2.en = en;
    assign b2.window_len = wlen;
    assign b2.spike_in = spk;

    spike_rate_decoder #(.WIN_W(8), .CNT_W(8), .EDGE_MODE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    spike_rate_decoder #(.WIN_W(8), .CNT_W(3), .EDGE_MODE(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    spike_rate_decoder #(.WIN_W(8), .CNT_W(3), .EDGE_MODE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic s);
        en = e;
        spk = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] r, input logic [7:0] l,
                           input logic f, input logic o);
        chk({tag, "_rate"}, 32'(b0.rate_out), 32'(r));
        chk({tag, "_lat"}, 32'(b0.latency_out), 32'(l));
        chk({tag, "_seen"}, 32'(b0.first_seen), 32'(f));
        chk({tag, "_ovf"}, 32'(b0.overflow), 32'(o));
    endtask

    initial begin
        logic s4 [7];
        s4 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        step(0, 0);
        step(0, 0);
        chk("rst_valid", 32'(b0.valid), 0);
        chk_res("rst", 8'd0, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;

        // window of 8 with spikes at cycles 2, 5, 7
        wlen = 8'd8;
        for (int i = 0; i < 8; i++) begin
            step(1, i == 2 || i == 5 || i == 7);
            if (i == 6) chk("w8_early_valid", 32'(b0.valid), 0);
        end
        chk("w8_valid", 32'(b0.valid), 1);
        chk_res("w8", 8'd3, 8'd2, 1'b1, 1'b0);

        // two empty windows of 4
        step(0, 0);
        chk("abort_valid", 32'(b0.valid), 0);
        wlen = 8'd4;
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            chk($sformatf("w4_valid%0d", i), 32'(b0.valid), (i == 3 || i == 7) ? 1 : 0);
            if (i == 3 || i == 7) chk_res("w4", 8'd0, 8'hFF, 1'b0, 1'b0);
        end

        // saturation: spike held for a 10-cycle window
        step(0, 0);
        wlen = 8'd10;
        for (int i = 0; i < 10; i++) step(1, 1);
        chk("sat_valid", 32'(b0.valid), 1);
        chk_res("sat8", 8'd10, 8'd0, 1'b1, 1'b0);
        chk("sat3_rate", 32'(b1.rate_out), 7);
        chk("sat3_ovf", 32'(b1.overflow), 1);
        chk("sat3_lat", 32'(b1.latency_out), 0);
        chk("edge_rate", 32'(b2.rate_out), 1);
        chk("edge_ovf", 32'(b2.overflow), 0);
        chk("edge_lat", 32'(b2.latency_out), 0);

        // window_len 0 then 1: result every cycle mirrors the sample
        step(0, 0);
        wlen = 8'd0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) wlen = 8'd1;
            step(1, s4[i]);
            chk($sformatf("len1_valid%0d", i), 32'(b0.valid), 1);
            chk($sformatf("len1_rate%0d", i), 32'(b0.rate_out), 32'(s4[i]));
            chk($sformatf("len1_lat%0d", i), 32'(b0.latency_out), s4[i] ? 0 : 32'hFF);
        end

        // abort at window cycle 3 of 8, then a full window with spikes at 1 and 4
        step(0, 0);
        wlen = 8'd8;
        step(1, 0);
        step(1, 1);
        step(1, 0);
        step(0, 0);
        chk("abort3_valid", 32'(b0.valid), 0);
        chk_res("abort3", 8'd1, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1, i == 1 || i == 4);
            if (i < 7) chk($sformatf("re_valid%0d", i), 32'(b0.valid), 0);
        end
        chk("re_valid", 32'(b0.valid), 1);
        chk_res("re", 8'd2, 8'd1, 1'b1, 1'b0);

        // reset mid-window after 4 counted spikes
        step(0, 0);
        step(1, 1);
        step(1, 1);
        step(1, 0);
        step(1, 1);
        step(1, 1);
        rst = 1'b1;
        step(1, 1);
        chk("mrst_valid", 32'(b0.valid), 0);
        chk_res("mrst", 8'd0, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1, i == 6);
        chk("post_valid", 32'(b0.valid), 1);
        chk_res("post", 8'd1, 8'd6, 1'b1, 1'b0);
        step(0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side decoder for the LIF neuron spike outputs. It converts a spike train back into a number: the spike count over a programmable window, plus the latency of the first spike in that window. Each window ends with a single-cycle `valid` strobe, which makes neuron output observable on the dedicated and bidirectional pins. It sits between a `lif` instance's `spike` output and the top-level output muxing, and is the inverse of driving a neuron with an input current.

## Interface
Parameters:
- `WIN_W`, default 8: width of the window length and window cycle index.
- `CNT_W`, default 8: width of the spike count.
- `EDGE_MODE`, default 0: 0 counts every cycle `spike_in`=1; 1 counts only 0→1 transitions of `spike_in`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  decoder enable; low aborts any window in progress.
- `window_len`  in  WIN_W  window length in cycles; 0 is treated as 1; sampled at window start.
- `spike_in`  in  1  spike from a neuron, one sample per cycle.
- `rate_out`  out  CNT_W  spike count of the last completed window; saturates at 2^CNT_W−1.
- `latency_out`  out  WIN_W  window cycle index of the first counted spike; all-ones if no spike.
- `first_seen`  out  1  1 if the last completed window contained at least one counted spike.
- `overflow`  out  1  1 if the last completed window's count saturated.
- `valid`  out  1  one-cycle strobe; the four outputs above update in the same cycle.

## Operation
State machine, two states:
- **IDLE**
  - Entered at reset or whenever `en`=0.
  - Window counter, spike count, first-spike tracker and edge history are all cleared.
  - Result outputs hold their last values.
- **RUN**
  - Window in progress.
  - `win_idx` counts 0..`len`−1.
  - `len` is the latched `window_len`, with 0 mapped to 1.

Transitions:
- IDLE with `en`=1: this cycle is window cycle 0. Latch `len`, evaluate the spike, go to RUN (or complete immediately if `len`=1).
- RUN with `en`=0: abort to IDLE. No `valid`; the partial count is discarded.
- RUN, last cycle (`win_idx`=`len`−1): complete the window (below). If `en`=1, the next cycle is cycle 0 of a new window; `window_len` is re-sampled at that point. Windows run back-to-back with no gap cycle.

Counted spike:
- `EDGE_MODE`=0: `spike_in`=1.
- `EDGE_MODE`=1: `spike_in`=1 and the previous-cycle sample was 0.
- The previous-cycle sample is reset to 0 in IDLE, so a spike already high on window cycle 0 of the first window counts.
- Across back-to-back windows the history is not reset.

Count:
- A counted spike increments `count`, saturating at 2^CNT_W−1.
- An increment attempted at saturation sets the window's `ovf` flag.
- On the first counted spike of a window, record `win_idx` into `lat` and set `seen`.

Window completion (last cycle):
- The last-cycle spike is included.
- Next edge: `rate_out`←final count, `latency_out`←`lat` (all-ones if not `seen`), `first_seen`←`seen`, `overflow`←`ovf`, `valid`←1.
- Internal count, `lat`, `seen` and `ovf` are cleared for the next window.

Reset:
- All outputs go to 0, except `latency_out`, which goes to all-ones.
- `rst` has priority over `en`. Asserting it mid-window discards the window with no `valid`.

## Timing
- `valid` is high for exactly one cycle: the cycle after the window's last sample cycle.
- First `valid` after `en` rises (en high in cycle t) is at cycle t+`len`.
- Steady state with constant `en`=1: one `valid` every `len` cycles.
- `len`=1: `valid` every cycle. `rate_out` is 0 or 1; `latency_out` is 0 or all-ones.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Changing `window_len` mid-window has no effect until the next window start.

## Test plan
- Reset, then `en`=1, `window_len`=8, spikes at window cycles 2, 5, 7 (`EDGE_MODE`=0) → `valid` 8 cycles after `en`; `rate_out`=3, `latency_out`=2, `first_seen`=1, `overflow`=0.
- `window_len`=4, no spikes for two windows → two `valid` pulses 4 cycles apart; `rate_out`=0, `latency_out`=8'hFF, `first_seen`=0.
- `CNT_W`=3, `window_len`=10, `spike_in` held at 1 → `rate_out`=7, `overflow`=1, `latency_out`=0. Repeat with `EDGE_MODE`=1 → `rate_out`=1, `overflow`=0.
- `window_len`=0 and `window_len`=1 → `valid` every cycle; `rate_out` mirrors the previous cycle's `spike_in`.
- `en` dropped at window cycle 3 of 8 → no `valid`, outputs unchanged. Re-raise `en` with 2 spikes in 8 cycles → `rate_out`=2.
- `rst` pulsed mid-window with 4 spikes counted → outputs at reset values, no `valid`. The next full window counts from 0.
